// File: rtl/vga_pkg.sv
// Shared constants and types for the scaled 128x96 video path.
package vga_pkg;

  localparam int unsigned SCL_H_RES   = 128;
  localparam int unsigned SCL_V_RES   = 96;
  localparam int unsigned VRAM_DEPTH  = SCL_H_RES * SCL_V_RES;
  localparam int unsigned VRAM_ADDR_W = 14;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned WAIT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vram_rd_pipe.sv
// Read-return pipeline: turns an issued VRAM read into a fixed-latency
// valid/data pulse. Reset flushes any read still in flight.
module vram_rd_pipe #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_issue_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              s1_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // s1_q marks the cycle in which the RAM presents the addressed word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      s1_q    <= rd_issue_i;
      valid_q <= s1_q;
      if (s1_q) begin
        data_q <= ram_rdata_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/vram_access_arbiter.sv
// Arbitrates the single-port VRAM between fixed-latency display reads
// and a lower-priority frame writer that fills idle (or vblank) slots.
module vram_access_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned H_RES         = SCL_H_RES,
  parameter int unsigned V_RES         = SCL_V_RES,
  parameter int unsigned ADDR_W        = VRAM_ADDR_W,
  parameter int unsigned DATA_W        = PIX_W,
  parameter bit          WR_BLANK_ONLY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              wr_starved,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned       DEPTH    = H_RES * V_RES;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  arb_state_t        state_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              wr_ack_q;
  logic              wr_err_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic              starved_q;

  logic wr_eligible_c;
  logic wr_in_range_c;

  assign wr_eligible_c = wr_req & (vblank | ~WR_BLANK_ONLY);
  assign wr_in_range_c = 32'(wr_addr) < DEPTH;

  // Display always wins; a write is never granted two cycles running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      if (disp_req) begin
        state_q    <= RD;
        ram_addr_q <= disp_addr;
      end else if (wr_eligible_c && (state_q != WR)) begin
        state_q  <= WR;
        wr_ack_q <= 1'b1;
        wr_err_q <= ~wr_in_range_c;
        // Out-of-range writes are acknowledged but never reach the RAM.
        if (wr_in_range_c) begin
          ram_addr_q  <= wr_addr;
          ram_we_q    <= 1'b1;
          ram_wdata_q <= wr_data;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  // Wait counter: cycles a write has been pending without an ack.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!wr_req || wr_ack_q) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      starved_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      starved_q  <= (wait_cnt_d == WAIT_MAX);
    end
  end

  vram_rd_pipe #(
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk         (clk),
    .reset       (reset),
    .rd_issue_i  (state_q == RD),
    .ram_rdata_i (ram_rdata),
    .valid_o     (disp_valid),
    .data_o      (disp_data)
  );

  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign wr_starved = starved_q;

endmodule
